// File: rtl/bus_read_router.sv
// rtl/bus_read_router.sv - routes one of NUM_SRC source words onto the engine data return bus
// Source picked by the top address bits at read start; handshake, hold-until-release, timeout and error states.
module bus_read_router #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 16,
  parameter int NUM_SRC  = 4,
  parameter int SEL_BITS = 3,
  parameter int TIMEOUT  = 15,
  parameter int LOOPBACK = 1
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      nRead,
  input  logic                      nWrite,
  input  logic [ADDR_W-1:0]         Address,
  input  logic [DATA_W-1:0]         ExecDataIn,
  input  logic [NUM_SRC*DATA_W-1:0] SrcData,
  input  logic [NUM_SRC-1:0]        SrcValid,
  output logic [DATA_W-1:0]         DataOut,
  output logic                      DataValid,
  output logic                      BusError,
  output logic                      Busy
);

  localparam int NUM_SLOTS = 1 << SEL_BITS;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_BITS:0]   SRC_LIMIT = (SEL_BITS + 1)'(NUM_SRC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_ERR} state_t;

  state_t              r_state, w_state_nxt;
  logic [SEL_BITS-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_data_out, w_data_nxt;
  logic                r_data_valid, w_valid_nxt;

  logic [DATA_W-1:0]   w_slot_data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_slot_valid;
  logic [SEL_BITS-1:0] w_req_idx;
  logic                w_req_mapped;

  // Pad the source set out to the full decode range so any idx indexes safely; empty slots never go valid.
  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      if (g < NUM_SRC) begin : g_src
        assign w_slot_data[g]  = SrcData[g*DATA_W +: DATA_W];
        assign w_slot_valid[g] = SrcValid[g];
      end else begin : g_empty
        assign w_slot_data[g]  = '0;
        assign w_slot_valid[g] = 1'b0;
      end
    end
  endgenerate

  assign w_req_idx    = Address[ADDR_W-1 -: SEL_BITS];
  assign w_req_mapped = ({1'b0, w_req_idx} < SRC_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_out;
    w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!nRead && !nWrite) begin
          w_state_nxt = S_ERR;
          w_data_nxt  = '1;
        end else if (!nRead) begin
          w_idx_nxt = w_req_idx;
          w_cnt_nxt = '0;
          if (w_req_mapped) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_ERR;
            w_data_nxt  = '1;
          end
        end else if (!nWrite && (LOOPBACK != 0)) begin
          w_data_nxt = ExecDataIn;
        end
      end
      S_WAIT: begin
        // Release wins over a same-cycle SrcValid so an aborted read never returns data.
        if (nRead) begin
          w_state_nxt = S_IDLE;
        end else if (w_slot_valid[r_idx]) begin
          w_data_nxt  = w_slot_data[r_idx];
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = S_ERR;
          w_data_nxt  = '1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (nRead) w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (nRead && nWrite) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_data_out   <= w_data_nxt;
      r_data_valid <= w_valid_nxt;
    end
  end

  assign DataOut   = r_data_out;
  assign DataValid = r_data_valid;
  assign BusError  = (r_state == S_ERR);
  assign Busy      = (r_state != S_IDLE);

endmodule

// File: doc/bus_read_router.md
Name: bus_read_router

Overview:
- Parametrised successor to the fixed shared-bus data mux.
- Routes one of NUM_SRC source data words onto the single data return bus to the execution engine.
- Source is selected by the upper address bits, latched when a read starts.
- Adds a per-read handshake (source valid), a registered output, a hold-until-release protocol, a timeout counter and error signalling for unmapped or stalled reads; optional write loopback of the engine's own output.

Parameters:
- DATA_W, 256, data bus width.
- ADDR_W, 16, address width.
- NUM_SRC, 4, number of read sources (1..2**SEL_BITS).
- SEL_BITS, 3, number of top address bits decoded into the source index.
- TIMEOUT, 15, WAIT cycles allowed before a read errors (>=1).
- LOOPBACK, 1, 1 = during writes DataOut tracks ExecDataIn.

Ports:
- Clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- nRead  input  1  active-low read strobe from execution engine.
- nWrite  input  1  active-low write strobe from execution engine.
- Address  input  ADDR_W  bus address from execution engine.
- ExecDataIn  input  DATA_W  execution engine output data (loopback source).
- SrcData  input  NUM_SRC*DATA_W  packed source data; source i at bits [i*DATA_W +: DATA_W].
- SrcValid  input  NUM_SRC  per-source data-valid.
- DataOut  output  DATA_W  registered data to execution engine.
- DataValid  output  1  one-cycle pulse: DataOut newly loaded with read data.
- BusError  output  1  high while in ERR.
- Busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, nReset=0): state=IDLE, DataOut=0, DataValid=0, BusError=0, Busy=0, idx=0, cnt=0.
- idx = Address[ADDR_W-1 -: SEL_BITS], sampled only on IDLE->request.
- All outputs are registered. DataValid defaults to 0 every cycle unless set below.
- IDLE:
  - nRead=0 and nWrite=0 together: protocol violation -> ERR.
  - nRead=0, nWrite=1: latch idx, cnt=0.
    - idx >= NUM_SRC -> ERR.
    - otherwise -> WAIT.
  - nWrite=0, nRead=1: stay IDLE. If LOOPBACK=1, DataOut<=ExecDataIn each cycle; DataValid stays 0.
  - Otherwise DataOut holds.
- WAIT (priority order):
  - nRead=1: abort -> IDLE, no DataValid, no error. Abort beats SrcValid in the same cycle.
  - SrcValid[idx]=1: DataOut<=SrcData[idx], DataValid<=1 -> HOLD.
  - cnt==TIMEOUT-1: -> ERR.
  - otherwise cnt<=cnt+1.
  - cnt saturates; it never wraps.
- HOLD:
  - DataOut held; Address, SrcValid and nWrite changes are ignored.
  - nRead=1 -> IDLE.
- ERR:
  - On entry DataOut<={DATA_W{1'b1}}; BusError=1.
  - Leave to IDLE only when nRead=1 and nWrite=1 in the same cycle.
- Latency: request sampled at edge N with source already valid -> DataOut/DataValid updated at edge N+1.
  - Minimum read-to-read spacing: one IDLE cycle between releases.
- Non-selected SrcValid bits are ignored in all states.
- Reset mid-read: immediate IDLE, outputs cleared, no DataValid; pending source data is discarded.
- NUM_SRC == 2**SEL_BITS: the error decode path is unreachable for idx; the violation and timeout paths remain.

Test Plan:
- Defaults. Address=0x2000 (idx 1), nRead=0, SrcValid=4'b0010, SrcData[1]=0xA5..A5 -> DataOut=0xA5..A5 and DataValid=1 one edge after the request. Busy=1 until nRead=1, then IDLE next edge.
- Address=0x6000 (idx 3), SrcValid[3] asserted 5 cycles after the request -> DataValid pulses exactly once, on the edge after SrcValid rises. SrcData[3] changes during HOLD do not alter DataOut.
- Address=0x8000 (idx 4 >= NUM_SRC), nRead=0 -> BusError=1 and DataOut=all-ones next edge. nRead=1, nWrite=1 -> IDLE, BusError=0.
- Address=0x0000, SrcValid never asserted -> ERR after 15 WAIT cycles. Repeat with nRead released at WAIT cycle 7 -> IDLE, no error. Release coincident with SrcValid[0] -> abort wins, DataValid=0.
- LOOPBACK=1: nWrite=0, ExecDataIn=0x1234 -> DataOut=0x1234 next edge, DataValid=0. nRead=0 and nWrite=0 together -> ERR.
- nReset pulsed low mid-WAIT (asynchronous, between edges) -> all outputs 0 immediately. A normal read afterwards completes correctly.
